// File: rtl/led_pattern_pkg.sv
// Shared types for the LED pattern generator: mode encoding, duty width and mode sequencing.
package led_pattern_pkg;

   localparam int unsigned DUTY_W = 8;

   typedef enum logic [1:0] {
      MODE_COUNT   = 2'd0,
      MODE_SHIFT   = 2'd1,
      MODE_BOUNCE  = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_e;

   // BOUNCE wraps to COUNT when the breathe mode is not built in.
   function automatic mode_e next_mode(input mode_e cur, input logic breathe_en);
      case (cur)
         MODE_COUNT:  return MODE_SHIFT;
         MODE_SHIFT:  return MODE_BOUNCE;
         MODE_BOUNCE: return breathe_en ? MODE_BREATHE : MODE_COUNT;
         default:     return MODE_COUNT;
      endcase
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low push-button conditioner: 2-FF synchronizer, stability counter and
// a one-cycle press pulse on each accepted 1->0 transition.
module key_debounce #(
   parameter int unsigned DEB_W = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic press
);

   logic             sync1;
   logic             sync2;
   logic             level;
   logic [DEB_W-1:0] cnt;
   logic [1:0]       fill;
   logic             armed;

   // A key held through reset never reached the synchronizer as a high sample,
   // so presses stay disarmed until a real released level has been seen.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
         fill  <= '0;
         armed <= 1'b0;
         press <= 1'b0;
      end else begin
         sync1 <= key;
         sync2 <= sync1;
         fill  <= {fill[0], 1'b1};
         press <= 1'b0;
         if (fill[1] && sync2) armed <= 1'b1;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (&cnt) begin
            cnt   <= '0;
            level <= sync2;
            press <= armed && !sync2;
         end else begin
            cnt <= cnt + DEB_W'(1);
         end
      end
   end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: COUNT / SHIFT / BOUNCE (and BREATHE when LED_PATTERN_BREATHE_EN
// is defined) selected by a debounced push-button, stepped by a 2^STEP_W prescaler.
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter int unsigned LED_W  = 8,
   parameter int unsigned STEP_W = 23,
   parameter int unsigned DEB_W  = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             KEY_MODE,
   input  logic             HOLD,
   output logic [LED_W-1:0] LED,
   output logic [1:0]       MODE,
   output logic             STEP
);

`ifdef LED_PATTERN_BREATHE_EN
   localparam logic BREATHE_EN = 1'b1;
`else
   localparam logic BREATHE_EN = 1'b0;
`endif

   logic              press;
   logic              tick_c;
   mode_e             mode_q,  mode_d;
   logic [LED_W-1:0]  led_q,   led_d;
   logic [STEP_W-1:0] presc_q, presc_d;
   logic              step_q,  step_d;
   logic              bdir_q,  bdir_d;
`ifdef LED_PATTERN_BREATHE_EN
   logic [DUTY_W-1:0] duty_q,  duty_d;
   logic              ddir_q,  ddir_d;
   logic [DUTY_W-1:0] pwm_q;
`endif

   key_debounce #(.DEB_W(DEB_W)) u_key (
      .clk   (CLK),
      .rst   (RST),
      .key   (KEY_MODE),
      .press (press)
   );

   assign tick_c = !HOLD && (&presc_q);

   always_ff @(posedge CLK) begin
      if (RST) begin
         mode_q  <= MODE_COUNT;
         led_q   <= '0;
         presc_q <= '0;
         step_q  <= 1'b0;
         bdir_q  <= 1'b1;
`ifdef LED_PATTERN_BREATHE_EN
         duty_q  <= '0;
         ddir_q  <= 1'b1;
         pwm_q   <= '0;
`endif
      end else begin
         mode_q  <= mode_d;
         led_q   <= led_d;
         presc_q <= presc_d;
         step_q  <= step_d;
         bdir_q  <= bdir_d;
`ifdef LED_PATTERN_BREATHE_EN
         duty_q  <= duty_d;
         ddir_q  <= ddir_d;
         pwm_q   <= pwm_q + DUTY_W'(1);
`endif
      end
   end

   // A mode advance takes priority over a coincident step tick.
   always_comb begin
      mode_d  = mode_q;
      led_d   = led_q;
      presc_d = presc_q;
      step_d  = 1'b0;
      bdir_d  = bdir_q;
`ifdef LED_PATTERN_BREATHE_EN
      duty_d  = duty_q;
      ddir_d  = ddir_q;
`endif
      if (press) begin
         mode_d  = next_mode(mode_q, BREATHE_EN);
         presc_d = '0;
         bdir_d  = 1'b1;
         led_d   = (mode_d == MODE_SHIFT || mode_d == MODE_BOUNCE) ? LED_W'(1) : '0;
`ifdef LED_PATTERN_BREATHE_EN
         duty_d  = '0;
         ddir_d  = 1'b1;
`endif
      end else begin
         if (!HOLD) presc_d = presc_q + STEP_W'(1);
         if (tick_c) begin
            step_d = 1'b1;
            case (mode_q)
               MODE_COUNT: led_d = led_q + LED_W'(1);
               MODE_SHIFT: led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
               MODE_BOUNCE: begin
                  if (bdir_q) begin
                     if (led_q[LED_W-1]) begin
                        led_d  = led_q >> 1;
                        bdir_d = 1'b0;
                     end else begin
                        led_d  = led_q << 1;
                     end
                  end else begin
                     if (led_q[0]) begin
                        led_d  = led_q << 1;
                        bdir_d = 1'b1;
                     end else begin
                        led_d  = led_q >> 1;
                     end
                  end
               end
               default: begin
`ifdef LED_PATTERN_BREATHE_EN
                  if (ddir_q) begin
                     if (&duty_q) begin
                        duty_d = duty_q - DUTY_W'(1);
                        ddir_d = 1'b0;
                     end else begin
                        duty_d = duty_q + DUTY_W'(1);
                     end
                  end else begin
                     if (duty_q == '0) begin
                        duty_d = DUTY_W'(1);
                        ddir_d = 1'b1;
                     end else begin
                        duty_d = duty_q - DUTY_W'(1);
                     end
                  end
`endif
               end
            endcase
         end
`ifdef LED_PATTERN_BREATHE_EN
         // PWM output follows the free-running counter even while HOLD freezes the duty.
         if (mode_q == MODE_BREATHE) led_d = {LED_W{pwm_q < duty_q}};
`endif
      end
   end

   assign LED  = led_q;
   assign MODE = mode_q;
   assign STEP = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen (LED_W=4, STEP_W=2, DEB_W=2); honours LED_PATTERN_BREATHE_EN.
module tb_led_pattern_gen;

   localparam int unsigned LED_W  = 4;
   localparam int unsigned STEP_W = 2;
   localparam int unsigned DEB_W  = 2;

   logic             clk;
   logic             rst;
   logic             key_mode;
   logic             hold;
   logic [LED_W-1:0] led;
   logic [1:0]       mode;
   logic             step;

   int checks = 0;
   int errors = 0;

   led_pattern_gen #(.LED_W(LED_W), .STEP_W(STEP_W), .DEB_W(DEB_W)) dut (
      .CLK      (clk),
      .RST      (rst),
      .KEY_MODE (key_mode),
      .HOLD     (hold),
      .LED      (led),
      .MODE     (mode),
      .STEP     (step)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Key low from a negedge; returns 7 negedges later, first cycle showing the new mode.
   task automatic key_press_start();
      key_mode = 1'b0;
      repeat (7) @(negedge clk);
   endtask

   task automatic key_release();
      repeat (3) @(negedge clk);
      key_mode = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; key_mode = 1'b1; hold = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({mode, led, step} !== {2'd0, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset: mode=%0d led=%0h step=%0b, expected mode=0 led=0 step=0", mode, led, step);
      end
      rst = 1'b0;
   endtask

   task automatic test_count();
      for (int k = 1; k <= 16; k++) begin
         repeat (3) begin
            @(negedge clk);
            checks++;
            if ({led, step} !== {4'(k - 1), 1'b0}) begin
               errors++;
               $display("FAIL count_hold k=%0d: led=%0h step=%0b, expected led=%0h step=0", k, led, step, 4'(k - 1));
            end
         end
         @(negedge clk);
         checks++;
         if ({led, step} !== {4'(k), 1'b1}) begin
            errors++;
            $display("FAIL count_step k=%0d: led=%0h step=%0b, expected led=%0h step=1", k, led, step, 4'(k));
         end
      end
   endtask

   task automatic test_shift();
      logic [3:0] exp_led [4];
      exp_led = '{4'd2, 4'd4, 4'd8, 4'd1};
      key_press_start();
      checks++;
      if ({mode, led, step} !== {2'd1, 4'd1, 1'b0}) begin
         errors++;
         $display("FAIL shift_enter: mode=%0d led=%0h step=%0b, expected mode=1 led=1 step=0", mode, led, step);
      end
      key_release();
      for (int j = 0; j < 4; j++) begin
         repeat ((j == 0) ? 1 : 4) @(negedge clk);
         checks++;
         if ({led, step} !== {exp_led[j], 1'b1}) begin
            errors++;
            $display("FAIL shift_step %0d: led=%0h step=%0b, expected led=%0h step=1", j, led, step, exp_led[j]);
         end
      end
      checks++;
      if (mode !== 2'd1) begin
         errors++;
         $display("FAIL shift_release: mode=%0d, expected 1", mode);
      end
   endtask

   task automatic test_hold();
      repeat (8) @(negedge clk);
      checks++;
      if ({led, step} !== {4'd4, 1'b1}) begin
         errors++;
         $display("FAIL hold_setup: led=%0h step=%0b, expected led=4 step=1", led, step);
      end
      hold = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if ({led, step} !== {4'd4, 1'b0}) begin
            errors++;
            $display("FAIL hold_freeze cycle %0d: led=%0h step=%0b, expected led=4 step=0", c, led, step);
         end
      end
      hold = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({led, step} !== {4'd4, 1'b0}) begin
         errors++;
         $display("FAIL hold_resume_wait: led=%0h step=%0b, expected led=4 step=0", led, step);
      end
      @(negedge clk);
      checks++;
      if ({led, step} !== {4'd8, 1'b1}) begin
         errors++;
         $display("FAIL hold_resume_step: led=%0h step=%0b, expected led=8 step=1", led, step);
      end
   endtask

   task automatic test_bounce();
      logic [3:0] exp_led [7];
      exp_led = '{4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd2};
      key_press_start();
      checks++;
      if ({mode, led} !== {2'd2, 4'd1}) begin
         errors++;
         $display("FAIL bounce_enter: mode=%0d led=%0h, expected mode=2 led=1", mode, led);
      end
      key_release();
      for (int j = 0; j < 7; j++) begin
         repeat ((j == 0) ? 1 : 4) @(negedge clk);
         checks++;
         if ({led, step} !== {exp_led[j], 1'b1}) begin
            errors++;
            $display("FAIL bounce_step %0d: led=%0h step=%0b, expected led=%0h step=1", j, led, step, exp_led[j]);
         end
      end
   endtask

   task automatic test_short_press();
      key_mode = 1'b0;
      repeat (2) @(negedge clk);
      key_mode = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if ({mode, led} !== {2'd2, 4'd4}) begin
         errors++;
         $display("FAIL short_press: mode=%0d led=%0h, expected mode=2 led=4", mode, led);
      end
   endtask

   // Each press cycle is 16 clocks, so the advance lands on a step-tick cycle.
   task automatic test_mode_cycle();
      logic [1:0] exp_mode [4];
      logic [3:0] exp_led  [4];
`ifdef LED_PATTERN_BREATHE_EN
      exp_mode = '{2'd1, 2'd2, 2'd3, 2'd0};
      exp_led  = '{4'd1, 4'd1, 4'd0, 4'd0};
`else
      exp_mode = '{2'd1, 2'd2, 2'd0, 2'd1};
      exp_led  = '{4'd1, 4'd1, 4'd0, 4'd1};
`endif
      for (int n = 0; n < 4 && mode != 2'd0; n++) begin
         key_press_start();
         key_release();
         repeat (6) @(negedge clk);
      end
      checks++;
      if (mode !== 2'd0) begin
         errors++;
         $display("FAIL cycle_to_count: mode=%0d, expected 0", mode);
      end
      for (int i = 0; i < 4; i++) begin
         key_press_start();
         checks++;
         if ({mode, led, step} !== {exp_mode[i], exp_led[i], 1'b0}) begin
            errors++;
            $display("FAIL cycle_press %0d: mode=%0d led=%0h step=%0b, expected mode=%0d led=%0h step=0",
                     i, mode, led, step, exp_mode[i], exp_led[i]);
         end
         key_release();
         repeat (6) @(negedge clk);
      end
   endtask

`ifdef LED_PATTERN_BREATHE_EN
   task automatic test_breathe();
      int on1 = 0;
      int on2 = 0;
      int bad = 0;
      repeat (3) begin
         key_press_start();
         key_release();
         repeat (6) @(negedge clk);
      end
      checks++;
      if (mode !== 2'd3) begin
         errors++;
         $display("FAIL breathe_enter: mode=%0d, expected 3", mode);
      end
      repeat (256) begin
         @(negedge clk);
         if (led == 4'hF) on1++;
         else if (led != 4'h0) bad++;
      end
      repeat (256) begin
         @(negedge clk);
         if (led == 4'hF) on2++;
         else if (led != 4'h0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL breathe_uniform: %0d samples with mixed bits, expected 0", bad);
      end
      checks++;
      if (!(on1 > 0 && on2 > on1)) begin
         errors++;
         $display("FAIL breathe_grow: on-cycles %0d then %0d, expected nonzero and increasing", on1, on2);
      end
   endtask
`endif

   task automatic test_reset_mid();
      key_mode = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({mode, led, step} !== {2'd0, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid: mode=%0d led=%0h step=%0b, expected mode=0 led=0 step=0", mode, led, step);
      end
      rst = 1'b0;
      repeat (12) @(negedge clk);
      checks++;
      if ({mode, led, step} !== {2'd0, 4'd3, 1'b1}) begin
         errors++;
         $display("FAIL held_key: mode=%0d led=%0h step=%0b, expected mode=0 led=3 step=1", mode, led, step);
      end
      key_release();
      repeat (6) @(negedge clk);
      key_press_start();
      checks++;
      if ({mode, led} !== {2'd1, 4'd1}) begin
         errors++;
         $display("FAIL repress: mode=%0d led=%0h, expected mode=1 led=1", mode, led);
      end
      key_release();
      repeat (6) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_count();
      test_shift();
      test_hold();
      test_bounce();
      test_short_press();
      test_mode_cycle();
`ifdef LED_PATTERN_BREATHE_EN
      test_breathe();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
